// File: rtl/subterranean_pkg.sv
// subterranean_pkg: shared constants, FSM state type and sizing helpers for the Subterranean blocks.
package subterranean_pkg;
    localparam int STATE_W = 257;
    localparam int INJ_W   = 33;

    typedef enum logic [1:0] {IDLE, RUN, UNLOAD} state_t;

    function automatic int beats_for(input int w);
        return (STATE_W + w - 1) / w;
    endfunction

    // Injection word bit j lands on state position 176^j mod 257 (176 = 12^4 mod 257); -1 if none.
    function automatic int inj_slot(input int pos);
        int p;
        p = 1;
        for (int j = 0; j < INJ_W; j++) begin
            if (p == pos) return j;
            p = (p * 176) % STATE_W;
        end
        return -1;
    endfunction
endpackage

// File: rtl/subterranean_rounds_serial_if.sv
// subterranean_rounds_serial_if: control, serial load and serial unload signals of the rounds engine.
interface subterranean_rounds_serial_if
    import subterranean_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_CNT_W = 4
);
    logic                   start;
    logic [ROUND_CNT_W-1:0] rounds;
    logic [INJ_W-1:0]       inject;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   data_out_valid;
    logic                   data_out_ready;
    logic                   busy;
    logic                   finish;

    modport master (
        output start, rounds, inject, data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, busy, finish
    );
    modport slave (
        input  start, rounds, inject, data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, busy, finish
    );
endinterface

// File: rtl/subterranean_round.sv
// subterranean_round: one combinational Subterranean round (chi, iota, theta, pi) followed by injection.
module subterranean_round
    import subterranean_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [INJ_W-1:0]   inject,
    output logic [STATE_W-1:0] state_out
);
    logic [STATE_W-1:0] chi, th, pi_s;

    for (genvar i = 0; i < STATE_W; i++) begin : g_bit
        localparam int J = inj_slot(i);
        // chi with iota folded into bit 0
        assign chi[i]  = state_in[i] ^ (~state_in[(i + 1) % STATE_W] & state_in[(i + 2) % STATE_W]) ^ (i == 0);
        assign th[i]   = chi[i] ^ chi[(i + 3) % STATE_W] ^ chi[(i + 8) % STATE_W];
        assign pi_s[i] = th[(12 * i) % STATE_W];
        if (J >= 0) begin : g_inj
            assign state_out[i] = pi_s[i] ^ inject[J];
        end else begin : g_pass
            assign state_out[i] = pi_s[i];
        end
    end
endmodule

// File: rtl/subterranean_rounds_serial.sv
// subterranean_rounds_serial: serially loads a 257-bit state, runs R Subterranean rounds, unloads it serially.
module subterranean_rounds_serial
    import subterranean_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_CNT_W = 4
) (
    input logic                          clk,
    input logic                          arstn,
    subterranean_rounds_serial_if.slave  bus
);
    localparam int BEATS  = beats_for(DATA_WIDTH);
    localparam int BUF_W  = BEATS * DATA_WIDTH;
    localparam int BCNT_W = $clog2(BEATS + 1);
    localparam logic [BUF_W-1:0] STATE_MASK = BUF_W'({STATE_W{1'b1}});

    state_t                 state, state_nxt;
    logic [BUF_W-1:0]       buf_q, buf_ld;
    logic [ROUND_CNT_W-1:0] rnd_cnt;
    logic [BCNT_W-1:0]      beat_cnt;
    logic [INJ_W-1:0]       inj_q;
    logic [STATE_W-1:0]     rnd_out;
    logic                   fin_q, last_beat;

    subterranean_round u_round (
        .state_in  (buf_q[STATE_W-1:0]),
        .inject    (inj_q),
        .state_out (rnd_out)
    );

    assign buf_ld    = bus.data_in_valid ? {bus.data_in, buf_q[BUF_W-1:DATA_WIDTH]} : buf_q;
    assign last_beat = bus.data_out_ready && beat_cnt == BCNT_W'(BEATS - 1);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.rounds == '0) ? UNLOAD : RUN;
            RUN:     if (rnd_cnt == ROUND_CNT_W'(1)) state_nxt = UNLOAD;
            UNLOAD:  if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pad bits are cleared on start so that a zero-round pass still unloads a clean final beat.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            buf_q    <= '0;
            rnd_cnt  <= '0;
            beat_cnt <= '0;
            inj_q    <= '0;
            fin_q    <= 1'b0;
        end else begin
            fin_q <= state != UNLOAD && state_nxt == UNLOAD;
            case (state)
                IDLE: begin
                    buf_q <= bus.start ? (buf_ld & STATE_MASK) : buf_ld;
                    if (bus.start) begin
                        rnd_cnt <= bus.rounds;
                        inj_q   <= bus.inject;
                    end
                end
                RUN: begin
                    buf_q   <= BUF_W'(rnd_out);
                    rnd_cnt <= rnd_cnt - 1'b1;
                    inj_q   <= '0;
                end
                UNLOAD: begin
                    if (bus.data_out_ready) begin
                        buf_q    <= buf_q >> DATA_WIDTH;
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.data_in_ready  = state == IDLE;
        bus.data_out_valid = state == UNLOAD;
        bus.busy           = state == RUN;
        bus.finish         = fin_q;
        bus.data_out       = buf_q[DATA_WIDTH-1:0];
    end
endmodule
